// File: rtl/intpol2_dn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : intpol2_dn_pkg
// Description : Shared types and width helpers for the 2nd-order
//               interpolator down-path controller (intpol2_dn_ctrl).
//               - state_t    : controller state encoding
//               - calc_ch_w  : channel-select width, max(1, clog2(NCH))
//               - calc_ph_w  : phase width, max(1, LOG2_L)
//               Modules derive their CH_W / PH_W constants from these.
// Revision    : 1.0 - initial release
// ============================================================================
package intpol2_dn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRIME  = 3'd1,
        ST_RUN    = 3'd2,
        ST_REFILL = 3'd3,
        ST_BYP    = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Channel select is at least one bit wide even for a single channel.
    function automatic int calc_ch_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    function automatic int calc_ph_w(input int log2_l);
        return (log2_l > 1) ? log2_l : 1;
    endfunction

endpackage : intpol2_dn_pkg
`default_nettype wire

// File: rtl/intpol2_dn_cnt.sv
`default_nettype none
// ============================================================================
// Module      : intpol2_dn_cnt
// Description : Phase / channel / sample counters for intpol2_dn_ctrl.
//               The channel counter wraps at NCH-1, the phase counter wraps
//               naturally at L-1 (L is a power of two). The sample counter
//               never wraps; its width covers the largest legal ilen.
// Ports       : clk, rst       - clock, asynchronous active-high reset
//               clr            - synchronous clear of all counters
//               ch_step        - advance channel (wraps to 0 after NCH-1)
//               ph_step        - advance phase
//               smp_step       - advance sample (per-channel) count
//               ch, ph, smp    - counter values
//               ch_last        - channel counter at NCH-1
//               ph_last        - phase counter at L-1
// Revision    : 1.0 - initial release
// ============================================================================
module intpol2_dn_cnt
    import intpol2_dn_pkg::*;
#(
    parameter int NCH   = 1,
    parameter int CH_W  = calc_ch_w(NCH),
    parameter int PH_W  = 2,
    parameter int SMP_W = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ch_step,
    input  logic             ph_step,
    input  logic             smp_step,
    output logic [CH_W-1:0]  ch,
    output logic [PH_W-1:0]  ph,
    output logic [SMP_W-1:0] smp,
    output logic             ch_last,
    output logic             ph_last
);

    assign ch_last = (ch == CH_W'(NCH - 1));
    assign ph_last = &ph;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch  <= '0;
            ph  <= '0;
            smp <= '0;
        end else if (clr) begin
            ch  <= '0;
            ph  <= '0;
            smp <= '0;
        end else begin
            if (ch_step) begin
                ch <= ch_last ? '0 : ch + 1'b1;
            end
            if (ph_step) begin
                ph <= ph + 1'b1;
            end
            if (smp_step) begin
                smp <= smp + 1'b1;
            end
        end
    end

endmodule : intpol2_dn_cnt
`default_nettype wire

// File: rtl/intpol2_dn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : intpol2_dn_ctrl
// Description : Control FSM for an L-times 2nd-order (3-tap) interpolator
//               over NCH time-multiplexed channels. Primes three samples per
//               channel, emits L phases per channel per input sample, then
//               refills one sample per channel until ilen samples have been
//               consumed. A bypass mode streams raw samples straight through.
// Ports       : clk, rst              - clock, asynchronous active-high reset
//               start                 - one-cycle job start (ignored if busy)
//               empty_i, afull_i      - input FIFO empty / output FIFO almost full
//               ilen                  - samples per channel for the job
//               bypass                - pass-through mode, sampled at start
//               rd_en, wr_en          - input FIFO read / output FIFO write
//               ld_shift, ch_sel      - shift-register load and its channel
//               phase                 - interpolation phase k (x = k/L)
//               sel_bypass            - datapath mux selects raw sample
//               busy, done            - job active / one-cycle completion
//               stop_empty/stop_afull - stalled on empty input / full output
//               clear                 - datapath clear, asserted on accepted start
//               out_cnt               - write counter (INTPOL2_DN_STATUS_CNT_EN)
// Options     : define INTPOL2_DN_STATUS_CNT_EN to add the out_cnt port.
// Revision    : 1.0 - initial release
// ============================================================================
module intpol2_dn_ctrl
    import intpol2_dn_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LOG2_L     = 2,
    parameter int NCH        = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   empty_i,
    input  logic                                   afull_i,
    input  logic [DATA_WIDTH:0]                    ilen,
    input  logic                                   bypass,
    output logic                                   rd_en,
    output logic                                   wr_en,
    output logic                                   ld_shift,
    output logic [calc_ch_w(NCH)-1:0]              ch_sel,
    output logic [calc_ph_w(LOG2_L)-1:0]           phase,
    output logic                                   sel_bypass,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   stop_empty,
    output logic                                   stop_afull,
    output logic                                   clear
`ifdef INTPOL2_DN_STATUS_CNT_EN
    ,
    output logic [DATA_WIDTH+LOG2_L+$clog2(NCH):0] out_cnt
`endif
);

    localparam int CH_W  = calc_ch_w(NCH);
    localparam int PH_W  = calc_ph_w(LOG2_L);
    localparam int SMP_W = DATA_WIDTH + 1;

    state_t             r_state;
    logic [SMP_W-1:0]   r_ilen;
    logic               r_ld_pend;
    logic               r_byp_wr_pend;
    logic [CH_W-1:0]    r_ld_ch;

    logic [CH_W-1:0]    w_cnt_ch;
    logic [PH_W-1:0]    w_cnt_ph;
    logic [SMP_W-1:0]   w_cnt_smp;
    logic               w_ch_last;
    logic               w_ph_last;

    logic               w_is_fill;
    logic               w_is_run;
    logic               w_is_byp;
    logic               w_byp_open;
    logic               w_start_acc;
    logic               w_rd_acc;
    logic               w_wr_run;

    always_comb begin
        w_is_fill   = (r_state == ST_PRIME) || (r_state == ST_REFILL);
        w_is_run    = (r_state == ST_RUN);
        w_is_byp    = (r_state == ST_BYP);
        // Bypass still has reads outstanding until ilen rounds of NCH reads.
        w_byp_open  = w_is_byp && (w_cnt_smp != r_ilen);
        w_start_acc = (r_state == ST_IDLE) && start;
        w_rd_acc    = (w_is_fill && !empty_i) ||
                      (w_byp_open && !empty_i && !afull_i);
        // The first RUN cycle after a fill carries the final ld_shift on
        // ch_sel, so the write for channel 0 waits one cycle.
        w_wr_run    = w_is_run && !afull_i && !r_ld_pend;
    end

    intpol2_dn_cnt #(
        .NCH   (NCH),
        .CH_W  (CH_W),
        .PH_W  (PH_W),
        .SMP_W (SMP_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_start_acc),
        .ch_step  (w_rd_acc || (w_wr_run && w_ph_last)),
        .ph_step  (w_wr_run),
        .smp_step (w_rd_acc && w_ch_last),
        .ch       (w_cnt_ch),
        .ph       (w_cnt_ph),
        .smp      (w_cnt_smp),
        .ch_last  (w_ch_last),
        .ph_last  (w_ph_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_ilen        <= '0;
            r_ld_pend     <= 1'b0;
            r_byp_wr_pend <= 1'b0;
            r_ld_ch       <= '0;
        end else begin
            r_ld_pend     <= w_is_fill && w_rd_acc;
            r_byp_wr_pend <= w_is_byp && w_rd_acc;
            // Remember which channel a read belonged to for the follow-up
            // ld_shift (fill) or write (bypass) one cycle later.
            if (w_start_acc) begin
                r_ld_ch <= '0;
            end else if (w_rd_acc) begin
                r_ld_ch <= w_cnt_ch;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_ilen <= ilen;
                        if (bypass) begin
                            r_state <= ST_BYP;
                        end else if (ilen < SMP_W'(3)) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_PRIME;
                        end
                    end
                end
                ST_PRIME: begin
                    // Third pass over all channels completes the prime.
                    if (w_rd_acc && w_ch_last && (w_cnt_smp == SMP_W'(2))) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_wr_run && w_ph_last && w_ch_last) begin
                        r_state <= (w_cnt_smp < r_ilen) ? ST_REFILL : ST_DONE;
                    end
                end
                ST_REFILL: begin
                    if (w_rd_acc && w_ch_last) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_BYP: begin
                    // The last pending write leaves in this same cycle.
                    if (!w_byp_open) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_en      = w_rd_acc;
    assign wr_en      = w_wr_run || (w_is_byp && r_byp_wr_pend);
    assign ld_shift   = r_ld_pend;
    assign ch_sel     = (w_is_run && !r_ld_pend) ? w_cnt_ch : r_ld_ch;
    assign phase      = w_cnt_ph;
    assign sel_bypass = w_is_byp;
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign stop_empty = (w_is_fill || w_byp_open) && empty_i;
    assign stop_afull = (w_is_run || w_byp_open) && afull_i;
    assign clear      = w_start_acc;

`ifdef INTPOL2_DN_STATUS_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt <= '0;
        end else if (w_start_acc) begin
            out_cnt <= '0;
        end else if (wr_en) begin
            out_cnt <= out_cnt + 1'b1;
        end
    end
`endif

endmodule : intpol2_dn_ctrl
`default_nettype wire

// File: tb/tb_intpol2_dn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_intpol2_dn_ctrl
// Description : Scoreboard bench for intpol2_dn_ctrl (NCH=2, L=4, 5-bit ilen).
//               Each job pushes its expected ld_shift channels and writes
//               (channel, phase, bypass flag) into queues; a monitor pops and
//               compares whenever the DUT shows ld_shift or wr_en.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intpol2_dn_ctrl;

    localparam int DW     = 4;
    localparam int LOG2_L = 2;
    localparam int L      = 1 << LOG2_L;
    localparam int NCH    = 2;
    localparam int CHW    = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              empty_i;
    logic              afull_i;
    logic [DW:0]       ilen;
    logic              bypass;
    logic              rd_en;
    logic              wr_en;
    logic              ld_shift;
    logic [CHW-1:0]    ch_sel;
    logic [LOG2_L-1:0] phase;
    logic              sel_bypass;
    logic              busy;
    logic              done;
    logic              stop_empty;
    logic              stop_afull;
    logic              clear;
`ifdef INTPOL2_DN_STATUS_CNT_EN
    logic [DW+LOG2_L+$clog2(NCH):0] out_cnt;
`endif

    intpol2_dn_ctrl #(
        .DATA_WIDTH (DW),
        .LOG2_L     (LOG2_L),
        .NCH        (NCH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .empty_i    (empty_i),
        .afull_i    (afull_i),
        .ilen       (ilen),
        .bypass     (bypass),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .ld_shift   (ld_shift),
        .ch_sel     (ch_sel),
        .phase      (phase),
        .sel_bypass (sel_bypass),
        .busy       (busy),
        .done       (done),
        .stop_empty (stop_empty),
        .stop_afull (stop_afull),
        .clear      (clear)
`ifdef INTPOL2_DN_STATUS_CNT_EN
        ,
        .out_cnt    (out_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CHW-1:0]    ch;
        logic [LOG2_L-1:0] ph;
        logic              byp;
    } wr_t;

    wr_t exp_wr_q[$];
    int  exp_ld_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_rd     = 0;
    int n_wr     = 0;
    int n_done   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows ld_shift / wr_en.
    initial begin : monitor
        logic prev_rd;
        wr_t  w;
        int   e;
        prev_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_rd = 1'b0;
            end else begin
                if (empty_i) chk("no_rd_when_empty", rd_en, 0);
                if (afull_i && busy && !sel_bypass) chk("no_wr_when_afull", wr_en, 0);
                if (ld_shift) begin
                    chk("ld_follows_rd", prev_rd, 1);
                    chk("ld_expected", exp_ld_q.size() != 0, 1);
                    if (exp_ld_q.size() != 0) begin
                        e = exp_ld_q.pop_front();
                        chk("ld_ch_sel", ch_sel, e);
                    end
                end
                if (wr_en) begin
                    n_wr++;
                    chk("wr_expected", exp_wr_q.size() != 0, 1);
                    if (exp_wr_q.size() != 0) begin
                        w = exp_wr_q.pop_front();
                        chk("wr_sel_bypass", sel_bypass, w.byp);
                        if (w.byp) begin
                            chk("byp_wr_follows_rd", prev_rd, 1);
                        end else begin
                            chk("wr_ch_sel", ch_sel, w.ch);
                            chk("wr_phase", phase, w.ph);
                        end
                    end
                end
                if (rd_en) n_rd++;
                if (done) n_done++;
                prev_rd = rd_en;
            end
        end
    end

    task automatic set_flags(input int mode, input int cyc);
        case (mode)
            1: begin
                empty_i = ($urandom_range(0, 3) == 0);
                afull_i = ($urandom_range(0, 3) == 0);
            end
            2: begin
                empty_i = cyc[0];
                afull_i = 1'b0;
            end
            default: begin
                empty_i = 1'b0;
                afull_i = 1'b0;
            end
        endcase
    endtask

    // Runs one job from a point just after a rising edge. The reference is
    // built straight from the job definition: ilen rounds of NCH reads, and
    // (ilen-2) passes of NCH channels x L phases of writes.
    task automatic run_job(input int len, input bit byp, input int mode,
                           input int afull_at, input int abort_at, output int cyc);
        int  exp_rd;
        int  exp_wr;
        int  d0;
        bit  did_afull;
        wr_t w;
        logic [LOG2_L-1:0] held;
        exp_wr_q.delete();
        exp_ld_q.delete();
        exp_rd = 0;
        if (byp) begin
            exp_rd = len * NCH;
            for (int i = 0; i < len * NCH; i++) begin
                w.ch = '0; w.ph = '0; w.byp = 1'b1;
                exp_wr_q.push_back(w);
            end
        end else if (len >= 3) begin
            exp_rd = len * NCH;
            for (int r = 0; r < len; r++)
                for (int c = 0; c < NCH; c++) exp_ld_q.push_back(c);
            for (int p = 0; p < len - 2; p++)
                for (int c = 0; c < NCH; c++)
                    for (int k = 0; k < L; k++) begin
                        w.ch = c[CHW-1:0]; w.ph = k[LOG2_L-1:0]; w.byp = 1'b0;
                        exp_wr_q.push_back(w);
                    end
        end
        exp_wr = exp_wr_q.size();
        n_rd = 0;
        n_wr = 0;
        d0 = n_done;
        did_afull = 1'b0;
        cyc = 0;

        ilen   = len[DW:0];
        bypass = byp;
        start  = 1'b1;
        set_flags(mode, 0);
        @(negedge clk);
        chk("clear_on_start", clear, 1);
        chk("idle_before_start", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);

        while (n_done == d0 && cyc < 5000) begin
            if (abort_at >= 0 && n_wr >= abort_at) return;
            if (afull_at >= 0 && !did_afull && n_wr == afull_at) begin
                did_afull = 1'b1;
                held = phase;
                afull_i = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("afull_no_wr", wr_en, 0);
                    chk("afull_stop", stop_afull, 1);
                    chk("afull_phase_held", phase, held);
                    @(posedge clk); #1;
                    cyc++;
                end
            end
            set_flags(mode, cyc);
            if (mode == 1) begin
                // Starts and bypass flips while busy must be ignored.
                start  = ($urandom_range(0, 7) == 0);
                bypass = $urandom_range(0, 1);
            end
            @(negedge clk);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("job_finished", n_done - d0, 1);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
        chk("rd_count", n_rd, exp_rd);
        chk("wr_count", n_wr, exp_wr);
        chk("ld_left_over", exp_ld_q.size(), 0);
        chk("wr_left_over", exp_wr_q.size(), 0);
`ifdef INTPOL2_DN_STATUS_CNT_EN
        chk("out_cnt", out_cnt, exp_wr);
`endif
        @(posedge clk); #1;
    endtask

    initial begin : stim
        int cyc;
        rst     = 1'b1;
        start   = 1'b0;
        empty_i = 1'b0;
        afull_i = 1'b0;
        bypass  = 1'b0;
        ilen    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {rd_en, wr_en, ld_shift, ch_sel, phase, sel_bypass,
                              busy, done, stop_empty, stop_afull, clear}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Clean jobs: ilen=5 (24 writes) and ilen=4 (16 writes).
        run_job(5, 1'b0, 0, -1, -1, cyc);
        run_job(4, 1'b0, 0, -1, -1, cyc);
        // Three-cycle output stall in the middle of the first RUN pass.
        run_job(5, 1'b0, 0, 6, -1, cyc);
        // Bypass with empty toggling every cycle.
        run_job(6, 1'b1, 2, -1, -1, cyc);
        // Too-short jobs go straight to DONE.
        run_job(2, 1'b0, 0, -1, -1, cyc);
        chk("short_job_cycles", cyc, 1);
        run_job(0, 1'b0, 0, -1, -1, cyc);
        chk("zero_job_cycles", cyc, 1);
        run_job(0, 1'b1, 0, -1, -1, cyc);

        // Reset while stalled in REFILL, then a full job must still run.
        run_job(5, 1'b0, 0, -1, L * NCH, cyc);
        empty_i = 1'b1;
        @(negedge clk);
        chk("refill_stop_empty", stop_empty, 1);
        chk("refill_busy", busy, 1);
        #1 rst = 1'b1;
        #1 chk("midjob_reset_outputs", {rd_en, wr_en, ld_shift, ch_sel, phase, sel_bypass,
                                        busy, done, stop_empty, stop_afull, clear}, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        empty_i = 1'b0;
        run_job(5, 1'b0, 1, -1, -1, cyc);

        // Randomized jobs with random FIFO stalls.
        for (int j = 0; j < 8; j++) begin
            run_job($urandom_range(0, 12), 1'($urandom_range(0, 1)), 1, -1, -1, cyc);
        end

        // Largest ilen for a 5-bit length field.
        run_job(31, 1'b0, 1, -1, -1, cyc);
        run_job(31, 1'b1, 1, -1, -1, cyc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_intpol2_dn_ctrl
`default_nettype wire

// File: doc/intpol2_dn_ctrl.md
INTPOL2_DN_CTRL -- requirements
Module: intpol2_dn_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the length field (ilen is DATA_WIDTH+1 bits).
REQ-002 SHALL have parameter LOG2_L, default 2, log2 of the interpolation factor L (range 1..6).
REQ-003 SHALL have parameter NCH, default 1, number of time-multiplexed channels (range 1..16).
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 Ports, one per line:
  clk  in  1  clock
  rst  in  1  asynchronous active-high reset
  start  in  1  one-cycle start pulse
  empty_i  in  1  input FIFO empty
  afull_i  in  1  output FIFO almost full
  ilen  in  DATA_WIDTH+1  input samples per channel
  bypass  in  1  sampled at start; pass-through mode
  rd_en  out  1  input FIFO read
  wr_en  out  1  output FIFO write
  ld_shift  out  1  shift M0<-M1<-M2<-data for channel ch_sel
  ch_sel  out  max(1,$clog2(NCH))  active channel
  phase  out  LOG2_L  interpolation phase k (x = k/L)
  sel_bypass  out  1  datapath mux to raw sample
  busy, done, stop_empty, stop_afull, clear  out  1 each

Function
REQ-006 States: IDLE, PRIME, RUN, REFILL, BYP, DONE.
REQ-007 IDLE: start with ilen<3 and bypass=0 -> DONE, zero writes; start with bypass=1 -> BYP; otherwise -> PRIME; clear asserted the start cycle.
REQ-008 PRIME: read 3*NCH samples, channel-interleaved (ch 0..NCH-1, repeated 3 times); each accepted read asserts rd_en and, one cycle later, ld_shift with matching ch_sel.
REQ-009 Reads SHALL occur only when empty_i=0; rd_en=0 and stop_empty=1 in any read cycle with empty_i=1.
REQ-010 RUN: for ch 0..NCH-1 (outer) and phase 0..L-1 (inner), one wr_en per cycle when afull_i=0; afull_i=1 holds counters, wr_en=0, stop_afull=1.
REQ-011 After last phase of last channel: consumed<ilen -> REFILL; else -> DONE.
REQ-012 REFILL: read NCH samples (one per channel, ld_shift each), then -> RUN, phase and ch_sel reset to 0.
REQ-013 Total writes = (ilen-2)*L*NCH per job.
REQ-014 BYP: sel_bypass=1; each read accepted when empty_i=0 and afull_i=0, wr_en one cycle after rd_en; ilen*NCH samples, then DONE.
REQ-015 DONE: done=1 for exactly one cycle, -> IDLE.
REQ-016 busy=1 in every state except IDLE; start ignored while busy.
REQ-017 empty_i and afull_i both high: stop_empty and stop_afull both asserted, no rd/wr.
REQ-018 Sample counter width DATA_WIDTH+1, no wrap; ilen max value SHALL complete correctly.

Reset
REQ-019 rst asserted (any state, mid-job included) -> IDLE, all outputs 0, counters 0, pending ld_shift cancelled.
REQ-020 First start after rst deassertion accepted on the next clock edge.

Configuration
REQ-021 Macro INTPOL2_DN_STATUS_CNT_EN defined: add output port out_cnt, width DATA_WIDTH+LOG2_L+$clog2(NCH)+1, counting wr_en pulses, cleared on start and reset, held after done.
REQ-022 Macro undefined: out_cnt port and counter absent; all other behaviour identical.

Structure
REQ-023 Package intpol2_dn_pkg SHALL hold the state enum and width helper constants (CH_W, PH_W).
REQ-024 One sub-module intpol2_dn_cnt: phase/channel/sample counters with terminal-count flags; FSM stays in the top.

Verification
REQ-025 L=4, NCH=1, ilen=5, FIFOs never stall -> 3 prime reads, 12 writes, phases 0,1,2,3 repeating, done pulse once.
REQ-026 NCH=2, ilen=4 -> prime ch order 0,1,0,1,0,1; 16 writes, ch_sel 0 for 4 then 1 for 4, per refill.
REQ-027 afull_i high 3 cycles mid-RUN -> wr_en 0 and stop_afull 1 for 3 cycles, phase held, total writes unchanged.
REQ-028 bypass=1, ilen=6, NCH=1, empty_i toggling -> 6 writes, each one cycle after its read, sel_bypass=1.
REQ-029 ilen=2, start -> DONE next cycle, zero rd_en/wr_en; rst mid-REFILL -> IDLE, outputs 0, next start runs full job.
